// File: rtl/alarm_pkg.sv
// Shared types for the alarm bank: channel states, BCD time and validity check.
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED,
        ARMED,
        PENDING,
        RINGING,
        SNOOZED
    } ch_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hh;
        bcd_t hl;
        bcd_t mh;
        bcd_t ml;
    } alarm_time_t;

    localparam int SNZ_W = 12;

    function automatic logic bcd_time_valid(alarm_time_t t);
        return (t.hh <= 4'd2) && (t.hl <= 4'd9) &&
               (t.mh <= 4'd5) && (t.ml <= 4'd9) &&
               !((t.hh == 4'd2) && (t.hl > 4'd3));
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, state machine, ring timeout,
// snooze countdown and per-trigger snooze count.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic        sec_zero_i,
    input  alarm_time_t now_i,
    input  logic        wr_i,
    input  alarm_time_t wr_time_i,
    input  logic        wr_arm_i,
    input  logic        grant_i,
    input  logic        off_i,
    input  logic        snz_i,
    output logic        ringing_o,
    output logic        pending_o,
    output logic        armed_o
);

    localparam logic [7:0]       RT_LAST  = 8'(RING_TIMEOUT_S - 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);
    localparam logic [3:0]       SNZ_MAX  = 4'(MAX_SNOOZE);

    ch_state_t        state_q, state_d;
    alarm_time_t      time_q, time_d;
    logic [7:0]       ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0] cd_q, cd_d;
    logic [3:0]       snz_cnt_q, snz_cnt_d;
    logic             go_snz;
    logic             go_off;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= DISARMED;
            time_q     <= '0;
            ring_cnt_q <= '0;
            cd_q       <= '0;
            snz_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            ring_cnt_q <= ring_cnt_d;
            cd_q       <= cd_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        ring_cnt_d = ring_cnt_q;
        cd_d       = cd_q;
        snz_cnt_d  = snz_cnt_q;
        go_snz     = 1'b0;
        go_off     = 1'b0;
        if (wr_i) begin
            time_d     = wr_time_i;
            ring_cnt_d = '0;
            cd_d       = '0;
            snz_cnt_d  = '0;
            state_d    = wr_arm_i ? ARMED : DISARMED;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (tick_i && sec_zero_i && (now_i == time_q))
                        state_d = PENDING;
                end
                PENDING: begin
                    if (grant_i) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
                RINGING: begin
                    // Buttons take precedence over a coincident tick.
                    go_snz = !off_i &&
                             (snz_i || (tick_i && ring_cnt_q == RT_LAST));
                    go_off = off_i || (go_snz && snz_cnt_q >= SNZ_MAX);
                    if (go_off) begin
                        state_d    = ARMED;
                        snz_cnt_d  = '0;
                        ring_cnt_d = '0;
                    end else if (go_snz) begin
                        state_d    = SNOOZED;
                        snz_cnt_d  = snz_cnt_q + 4'd1;
                        cd_d       = SNZ_LOAD;
                        ring_cnt_d = '0;
                    end else if (tick_i) begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                SNOOZED: begin
                    if (tick_i) begin
                        if (cd_q <= SNZ_W'(1)) begin
                            cd_d    = '0;
                            state_d = PENDING;
                        end else begin
                            cd_d = cd_q - SNZ_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ringing_o = (state_q == RINGING);
    assign pending_o = (state_q == PENDING);
    assign armed_o   = (state_q != DISARMED);

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm bank: write validation, button edge detection
// and lowest-index arbitration across alarm_channel instances.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARMS       = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3,
    localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                tick_1hz,
    input  logic [3:0]          now_hh,
    input  logic [3:0]          now_hl,
    input  logic [3:0]          now_mh,
    input  logic [3:0]          now_ml,
    input  logic [3:0]          now_sh,
    input  logic [3:0]          now_sl,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [3:0]          wr_hh,
    input  logic [3:0]          wr_hl,
    input  logic [3:0]          wr_mh,
    input  logic [3:0]          wr_ml,
    input  logic                wr_arm,
    input  logic                off_btn,
    input  logic                snooze_btn,
    output logic                ring,
    output logic [IW-1:0]       ring_idx,
    output logic [N_ALARMS-1:0] armed,
    output logic                wr_err
);

    alarm_time_t       now_t;
    alarm_time_t       wr_t;
    logic              sec_zero;
    logic [N_ALARMS-1:0] idx_hit;
    logic [N_ALARMS-1:0] wr_sel;
    logic [N_ALARMS-1:0] ringing;
    logic [N_ALARMS-1:0] pending;
    logic [N_ALARMS-1:0] grant;
    logic              wr_ok;
    logic              off_d1_q, off_d2_q;
    logic              snz_d1_q, snz_d2_q;
    logic              off_ev, snz_ev;
    logic              wr_err_q;
    logic              any_ring;
    logic              found;
    logic [IW-1:0]     idx_c;

    assign now_t    = '{hh: now_hh, hl: now_hl, mh: now_mh, ml: now_ml};
    assign wr_t     = '{hh: wr_hh, hl: wr_hl, mh: wr_mh, ml: wr_ml};
    assign sec_zero = (now_sh == 4'd0) && (now_sl == 4'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            off_d1_q <= 1'b0;
            off_d2_q <= 1'b0;
            snz_d1_q <= 1'b0;
            snz_d2_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            off_d1_q <= off_btn;
            off_d2_q <= off_d1_q;
            snz_d1_q <= snooze_btn;
            snz_d2_q <= snz_d1_q;
            wr_err_q <= wr_en && !wr_ok;
        end
    end

    assign off_ev = off_d1_q && !off_d2_q;
    assign snz_ev = snz_d1_q && !snz_d2_q && !off_ev;

    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            idx_hit[i] = (wr_idx == IW'(i));
        end
    end

    // Out-of-range channel indices are rejected like bad times.
    assign wr_ok  = bcd_time_valid(wr_t) && (|idx_hit);
    assign wr_sel = idx_hit & {N_ALARMS{wr_en && wr_ok}};

    always_comb begin
        any_ring = |ringing;
        grant    = '0;
        found    = 1'b0;
        idx_c    = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (!any_ring && !found && pending[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
            if (ringing[i]) idx_c = IW'(i);
        end
    end

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .SNOOZE_MIN    (SNOOZE_MIN),
            .RING_TIMEOUT_S(RING_TIMEOUT_S),
            .MAX_SNOOZE    (MAX_SNOOZE)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .tick_i    (tick_1hz),
            .sec_zero_i(sec_zero),
            .now_i     (now_t),
            .wr_i      (wr_sel[i]),
            .wr_time_i (wr_t),
            .wr_arm_i  (wr_arm),
            .grant_i   (grant[i]),
            .off_i     (off_ev),
            .snz_i     (snz_ev),
            .ringing_o (ringing[i]),
            .pending_o (pending[i]),
            .armed_o   (armed[i])
        );
    end

    assign ring     = any_ring;
    assign ring_idx = idx_c;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed-vector bench for alarm_bank: match, snooze, arbitration,
// timeout, write validation, button priority and async reset.
module tb_alarm_bank;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [3:0] now_hh = '0, now_hl = '0, now_mh = '0;
    logic [3:0] now_ml = '0, now_sh = '0, now_sl = '0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [3:0] wr_hh = '0, wr_hl = '0, wr_mh = '0, wr_ml = '0;
    logic       wr_arm = 1'b0;
    logic       off_btn = 1'b0, snooze_btn = 1'b0;
    logic       ring;
    logic [1:0] ring_idx;
    logic [3:0] armed;
    logic       wr_err;

    int nvec = 0;
    int nmis = 0;

    alarm_bank #(
        .N_ALARMS(4), .SNOOZE_MIN(5),
        .RING_TIMEOUT_S(60), .MAX_SNOOZE(3)
    ) u_dut (
        .CLK(CLK), .RST(RST), .tick_1hz(tick_1hz),
        .now_hh(now_hh), .now_hl(now_hl), .now_mh(now_mh),
        .now_ml(now_ml), .now_sh(now_sh), .now_sl(now_sl),
        .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_hh(wr_hh), .wr_hl(wr_hl), .wr_mh(wr_mh), .wr_ml(wr_ml),
        .wr_arm(wr_arm), .off_btn(off_btn), .snooze_btn(snooze_btn),
        .ring(ring), .ring_idx(ring_idx), .armed(armed), .wr_err(wr_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, int got, int exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(int idx, logic [3:0] a, logic [3:0] b,
                      logic [3:0] c, logic [3:0] d, logic arm);
        wr_en  = 1'b1;
        wr_idx = 2'(idx);
        wr_hh  = a; wr_hl = b; wr_mh = c; wr_ml = d;
        wr_arm = arm;
        cyc();
        wr_en  = 1'b0;
    endtask

    task automatic set_now(logic [3:0] a, logic [3:0] b, logic [3:0] c,
                           logic [3:0] d, logic [3:0] e, logic [3:0] f);
        now_hh = a; now_hl = b; now_mh = c;
        now_ml = d; now_sh = e; now_sl = f;
    endtask

    function automatic int snzcnt(int i);
        case (i)
            0: return int'(u_dut.g_ch[0].u_ch.snz_cnt_q);
            1: return int'(u_dut.g_ch[1].u_ch.snz_cnt_q);
            2: return int'(u_dut.g_ch[2].u_ch.snz_cnt_q);
            default: return int'(u_dut.g_ch[3].u_ch.snz_cnt_q);
        endcase
    endfunction

    initial begin
        #12;
        chk("rst_ring", int'(ring), 0);
        chk("rst_idx", int'(ring_idx), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_err", int'(wr_err), 0);
        RST = 1'b0;
        cyc();

        // ch1 = 07:30, match on the minute boundary
        wr(1, 0, 7, 3, 0, 1);
        chk("w1_err", int'(wr_err), 0);
        chk("w1_armed", int'(armed), 4'b0010);
        set_now(0, 7, 2, 9, 5, 9);
        tick();
        cyc();
        chk("pre_ring", int'(ring), 0);
        set_now(0, 7, 3, 0, 0, 0);
        tick();
        chk("match_c1", int'(ring), 0);
        cyc();
        chk("match_ring", int'(ring), 1);
        chk("match_idx", int'(ring_idx), 1);
        set_now(0, 7, 3, 0, 0, 1);

        // three snoozes, each re-rings after exactly 300 ticks
        for (int k = 1; k <= 3; k++) begin
            snooze_btn = 1'b1;
            cyc();
            chk("snz_hold", int'(ring), 1);
            cyc();
            chk("snz_fall", int'(ring), 0);
            snooze_btn = 1'b0;
            chk("snz_cnt", snzcnt(1), k);
            ticks(299);
            cyc();
            chk("snz_early", int'(ring), 0);
            tick();
            cyc();
            chk("snz_ring", int'(ring), 1);
            chk("snz_idx", int'(ring_idx), 1);
        end

        // fourth snooze acts as off
        snooze_btn = 1'b1;
        cyc();
        cyc();
        snooze_btn = 1'b0;
        chk("snz4_fall", int'(ring), 0);
        chk("snz4_armed", int'(armed), 4'b0010);
        chk("snz4_cnt", snzcnt(1), 0);
        ticks(305);
        cyc();
        chk("snz4_quiet", int'(ring), 0);

        // ch0 and ch2 both at 12:00, lowest index wins
        wr(0, 1, 2, 0, 0, 1);
        wr(2, 1, 2, 0, 0, 1);
        chk("arb_armed", int'(armed), 4'b0111);
        set_now(1, 2, 0, 0, 0, 0);
        tick();
        cyc();
        chk("arb_ring", int'(ring), 1);
        chk("arb_idx0", int'(ring_idx), 0);
        set_now(1, 2, 0, 0, 0, 1);
        off_btn = 1'b1;
        cyc();
        cyc();
        chk("off_fall", int'(ring), 0);
        cyc();
        off_btn = 1'b0;
        chk("arb_next", int'(ring), 1);
        chk("arb_idx2", int'(ring_idx), 2);

        // ch2 rings unattended into auto-snooze
        ticks(59);
        chk("to_hold", int'(ring), 1);
        tick();
        chk("to_fall", int'(ring), 0);
        chk("to_cnt", snzcnt(2), 1);
        chk("to_armed", int'(armed), 4'b0111);
        wr(2, 0, 0, 0, 0, 0);
        chk("dis_armed", int'(armed), 4'b0011);

        // write validation
        wr(0, 2, 4, 0, 0, 1);
        chk("bad24_err", int'(wr_err), 1);
        cyc();
        chk("err_pulse", int'(wr_err), 0);
        wr(0, 1, 2, 6, 0, 1);
        chk("bad60_err", int'(wr_err), 1);
        wr(3, 2, 3, 5, 9, 1);
        chk("ok2359_err", int'(wr_err), 0);
        chk("ok2359_arm", int'(armed), 4'b1011);
        set_now(1, 2, 0, 0, 0, 0);
        tick();
        cyc();
        chk("keep_ring", int'(ring), 1);
        chk("keep_idx", int'(ring_idx), 0);

        // off + snooze together behaves as off
        set_now(1, 2, 0, 0, 0, 1);
        off_btn = 1'b1;
        snooze_btn = 1'b1;
        cyc();
        cyc();
        off_btn = 1'b0;
        snooze_btn = 1'b0;
        chk("both_fall", int'(ring), 0);
        chk("both_cnt", snzcnt(0), 0);
        chk("both_armed", int'(armed), 4'b1011);

        // async reset mid-ring
        set_now(1, 2, 0, 0, 0, 0);
        cyc();
        tick();
        cyc();
        chk("pre_rst_ring", int'(ring), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_ring_drop", int'(ring), 0);
        chk("rst_armed_clr", int'(armed), 0);
        chk("rst_idx_clr", int'(ring_idx), 0);
        #5;
        RST = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
